evt_burst_gen: RTL and testbench
================================

# evt_burst_gen

Programmable event-pulse generator: on a start request it emits a burst of N single-cycle pulses on `evt_out`, spaced a programmable number of clock cycles apart, then signals completion. It is the source side of the event interface consumed by the design's event counters. It drives test stimulus, sample strobes and calibration ticks in the beamforming datapath.

## Interface

Parameters:

- `COUNT_WIDTH`, 16: width of the burst length and of the emitted-pulse count.
- `PERIOD_WIDTH`, 32: width of the pulse period.

Ports:

- `clk_in`, input, 1: system clock. This is the only clock.
- `rst_in`, input, 1: reset. Synchronous and active-high.
- `start_in`, input, 1: request a burst. Sampled only in IDLE.
- `count_in`, input, COUNT_WIDTH: number of pulses N. Latched on an accepted start.
- `period_in`, input, PERIOD_WIDTH: cycles from one pulse start to the next, P. Latched on an accepted start.
- `abort_in`, input, 1: terminate the active burst early.
- `evt_out`, output, 1: event pulse, one cycle wide.
- `busy_out`, output, 1: high while a burst is in progress.
- `done_out`, output, 1: one-cycle completion strobe.
- `sent_out`, output, COUNT_WIDTH: pulses emitted in the current or last burst.

## Operation

- FSM states: IDLE, PULSE, WAIT, DONE.
- All outputs are registered and Moore-decoded from state:
  - `evt_out` = (state == PULSE)
  - `busy_out` = state ∈ {PULSE, WAIT}
  - `done_out` = (state == DONE)
- IDLE:
  - On `start_in`: latch N and P, clear `sent_out` to 0.
  - If N == 0, go to DONE. Otherwise go to PULSE.
  - `start_in` is ignored in every other state. There is no queueing.
- P == 0 is treated as P == 1. P == 1 gives back-to-back pulses with `evt_out` held high for N cycles.
- PULSE: `sent_out` increments by 1. Priority order:
  1. `abort_in` → DONE.
  2. `sent_out`+1 == N → DONE.
  3. P == 1 → stay in PULSE.
  4. Otherwise → WAIT, with the timer loaded to P−2.
- WAIT: priority order:
  1. `abort_in` → DONE.
  2. Timer == 0 → PULSE.
  3. Otherwise decrement the timer.
- DONE: lasts exactly one cycle, then IDLE.
- `sent_out` holds its final value until the next accepted start.
- An abort during PULSE still delivers that cycle's pulse, and that pulse is counted.
- `abort_in` in IDLE or DONE has no effect.
- `abort_in` and `start_in` together in IDLE: the start is accepted.
- Arithmetic:
  - The timer is PERIOD_WIDTH bits, unsigned.
  - `sent_out` cannot overflow, because N ≤ 2^COUNT_WIDTH−1.
  - The comparison against N uses the latched value.
- Changes to `count_in` or `period_in` during a burst have no effect.

## Timing

- Reset values: state IDLE, `evt_out` 0, `busy_out` 0, `done_out` 0, `sent_out` 0, timer 0.
- Reset mid-burst: outputs reach their reset values in the cycle after `rst_in` is sampled. No further pulses are emitted.
- Start sampled at cycle T:
  - First pulse at T+1.
  - Pulse k (k = 0..N−1) at T+1+k·P.
  - `done_out` at T+1+(N−1)·P+1.
  - IDLE in the following cycle. A new start is accepted there at the earliest.
- N == 0: `done_out` at T+1, IDLE at T+2, no pulses.
- Abort sampled at cycle A while busy: `done_out` at A+1, and no pulse after A.
- Minimum start-to-start interval for back-to-back bursts: (N−1)·P+3 cycles.

## Structure

- Package `evt_pkg` holds:
  - the state enum `evt_gen_state_t`;
  - default width constants `EVT_COUNT_W` = 16 and `EVT_PERIOD_W` = 32.
- One natural sub-module, `evt_period_timer`:
  - Loadable down-counter with `load_in`, `value_in` and `zero_out`.
  - The FSM instantiates it for the WAIT interval.
- Target implementation size: 150–250 lines including the sub-module.

## Test plan

- Reset then idle: hold `rst_in` 3 cycles, then 20 idle cycles.
  - All outputs stay 0. `start_in` pulses during reset are ignored.
- N=3, P=4, start at T:
  - `evt_out` high exactly at T+1, T+5 and T+9.
  - `done_out` at T+10.
  - `sent_out` = 3.
  - `busy_out` high from T+1 to T+9.
- N=5, P=1 and P=0:
  - `evt_out` high for 5 consecutive cycles starting at T+1.
  - `done_out` at T+6.
  - `sent_out` = 5.
- N=0:
  - No pulse.
  - `done_out` at T+1.
  - `busy_out` never high.
  - `sent_out` = 0.
- N=10, P=3, `abort_in` during the WAIT after the 4th pulse:
  - `done_out` in the next cycle.
  - `sent_out` = 4, and no more pulses.
  - A start in the cycle after `done_out` is accepted, and `sent_out` is cleared.
- Busy-time controls, N=4, P=2:
  - `start_in` asserted every busy cycle and `count_in`/`period_in` changed mid-burst.
  - Exactly 4 pulses at the original spacing.
  - `rst_in` asserted at the 2nd pulse: no pulses after it.
  - Feeding `evt_out` into an event counter gives a count equal to `sent_out`.

Source files
------------

// File: rtl/evt_pkg.sv
// Shared types and default widths for the event-burst generator and its timer.
package evt_pkg;

    localparam int EVT_COUNT_W  = 16;
    localparam int EVT_PERIOD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT,
        DONE
    } evt_gen_state_t;

    typedef struct packed {
        logic evt;
        logic busy;
        logic done;
    } evt_outs_t;

    // Moore output decode; evaluated on the next state so the outputs can be registered.
    function automatic evt_outs_t evt_decode(input evt_gen_state_t st);
        evt_outs_t o;
        o.evt  = (st == PULSE);
        o.busy = (st == PULSE) || (st == WAIT);
        o.done = (st == DONE);
        return o;
    endfunction

endpackage

// File: rtl/evt_period_timer.sv
// Loadable down-counter that measures the idle gap between two pulses.
module evt_period_timer
    import evt_pkg::*;
#(
    parameter int WIDTH = EVT_PERIOD_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_in,
    input  logic             dec_in,
    input  logic [WIDTH-1:0] value_in,
    output logic             zero_out
);

    logic [WIDTH-1:0] count_q;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge values no matter how the blocks are ordered.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else if (load_in) begin
            count_q <= value_in;
        end else if (dec_in && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero_out = (count_q == '0);

endmodule

// File: rtl/evt_burst_gen.sv
// Burst generator: emits N one-cycle pulses spaced P cycles apart, then a done strobe.
module evt_burst_gen
    import evt_pkg::*;
#(
    parameter int COUNT_WIDTH  = EVT_COUNT_W,
    parameter int PERIOD_WIDTH = EVT_PERIOD_W
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    start_in,
    input  logic [COUNT_WIDTH-1:0]  count_in,
    input  logic [PERIOD_WIDTH-1:0] period_in,
    input  logic                    abort_in,
    output logic                    evt_out,
    output logic                    busy_out,
    output logic                    done_out,
    output logic [COUNT_WIDTH-1:0]  sent_out
);

    evt_gen_state_t          state_q;
    evt_outs_t               outs_q;
    logic [COUNT_WIDTH-1:0]  count_q;
    logic [COUNT_WIDTH-1:0]  sent_q;
    logic [COUNT_WIDTH-1:0]  sent_inc;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [PERIOD_WIDTH-1:0] gap_load;
    logic                    last_pulse;
    logic                    single_period;
    logic                    to_wait;
    logic                    in_wait;
    logic                    timer_zero;

    assign sent_inc      = sent_q + COUNT_WIDTH'(1);
    assign last_pulse    = (sent_inc == count_q);
    assign single_period = (period_q == PERIOD_WIDTH'(1));
    assign in_wait       = (state_q == WAIT);
    // The WAIT state covers P-1 cycles, with a zero count meaning "last gap cycle".
    assign gap_load      = period_q - PERIOD_WIDTH'(2);
    assign to_wait       = (state_q == PULSE) && !abort_in && !last_pulse && !single_period;

    evt_period_timer #(
        .WIDTH (PERIOD_WIDTH)
    ) u_timer (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .load_in  (to_wait),
        .dec_in   (in_wait),
        .value_in (gap_load),
        .zero_out (timer_zero)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            outs_q   <= '0;
            count_q  <= '0;
            period_q <= '0;
            sent_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        count_q  <= count_in;
                        period_q <= (period_in == '0) ? PERIOD_WIDTH'(1) : period_in;
                        sent_q   <= '0;
                        if (count_in == '0) begin
                            state_q <= DONE;
                            outs_q  <= evt_decode(DONE);
                        end else begin
                            state_q <= PULSE;
                            outs_q  <= evt_decode(PULSE);
                        end
                    end
                end
                PULSE: begin
                    sent_q <= sent_inc;
                    if (abort_in || last_pulse) begin
                        state_q <= DONE;
                        outs_q  <= evt_decode(DONE);
                    end else if (single_period) begin
                        state_q <= PULSE;
                        outs_q  <= evt_decode(PULSE);
                    end else begin
                        state_q <= WAIT;
                        outs_q  <= evt_decode(WAIT);
                    end
                end
                WAIT: begin
                    if (abort_in) begin
                        state_q <= DONE;
                        outs_q  <= evt_decode(DONE);
                    end else if (timer_zero) begin
                        state_q <= PULSE;
                        outs_q  <= evt_decode(PULSE);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    outs_q  <= evt_decode(IDLE);
                end
                default: begin
                    state_q <= IDLE;
                    outs_q  <= evt_decode(IDLE);
                end
            endcase
        end
    end

    assign evt_out  = outs_q.evt;
    assign busy_out = outs_q.busy;
    assign done_out = outs_q.done;
    assign sent_out = sent_q;

endmodule

// File: tb/tb_evt_burst_gen.sv
// Directed bench for evt_burst_gen: pulse schedule, zero/one periods, abort, reset and ignored inputs.
module tb_evt_burst_gen;

    localparam int CW = 16;
    localparam int PW = 32;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start_in;
    logic          abort_in;
    logic [CW-1:0] count_in;
    logic [PW-1:0] period_in;
    logic          evt_out;
    logic          busy_out;
    logic          done_out;
    logic [CW-1:0] sent_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    evt_burst_gen #(
        .COUNT_WIDTH  (CW),
        .PERIOD_WIDTH (PW)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .start_in  (start_in),
        .count_in  (count_in),
        .period_in (period_in),
        .abort_in  (abort_in),
        .evt_out   (evt_out),
        .busy_out  (busy_out),
        .done_out  (done_out),
        .sent_out  (sent_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are observed 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] outs3();
        return 32'({evt_out, busy_out, done_out});
    endfunction

    // Starts a burst and checks every cycle against the schedule pulse k at T+1+k*P.
    // With noise set, start_in is held through the burst and count/period change mid-burst.
    task automatic burst(input string tag, input int n, input int p, input bit noise);
        int pe;
        int last;
        int done_c;
        int pulses;
        bit e;
        bit b;
        bit d;
        pe     = (p == 0) ? 1 : p;
        last   = 1 + (n - 1) * pe;
        done_c = (n == 0) ? 1 : last + 1;
        pulses = 0;
        count_in  = CW'(n);
        period_in = PW'(p);
        start_in  = 1'b1;
        tick();
        for (int c = 1; c <= done_c + 1; c++) begin
            e = (n > 0) && (c <= last) && (((c - 1) % pe) == 0);
            b = (n > 0) && (c <= last);
            d = (c == done_c);
            check($sformatf("%s c%0d", tag, c), outs3(), 32'({e, b, d}));
            if (c == 1) check($sformatf("%s sent_cleared", tag), 32'(sent_out), 32'd0);
            if (evt_out) pulses++;
            start_in = noise && (n > 0) && (c <= last);
            if (noise && c == 2) begin
                count_in  = CW'(9);
                period_in = PW'(7);
            end
            if (c < done_c + 1) tick();
        end
        start_in = 1'b0;
        check($sformatf("%s sent", tag), 32'(sent_out), 32'(n));
        check($sformatf("%s evt_count", tag), 32'(pulses), 32'(n));
    endtask

    initial begin
        rst_in    = 1'b1;
        start_in  = 1'b0;
        abort_in  = 1'b0;
        count_in  = CW'(5);
        period_in = PW'(2);

        // Reset held 3 cycles with start pulses that must be ignored.
        for (int i = 0; i < 3; i++) begin
            start_in = (i != 1);
            tick();
            check($sformatf("reset c%0d", i), 32'({evt_out, busy_out, done_out, sent_out}), 32'd0);
        end
        rst_in   = 1'b0;
        start_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("idle c%0d", i), 32'({evt_out, busy_out, done_out, sent_out}), 32'd0);
        end

        burst("n3p4", 3, 4, 1'b0);
        burst("n5p1", 5, 1, 1'b0);
        burst("n5p0", 5, 0, 1'b0);
        burst("n0", 0, 4, 1'b0);

        // Abort in the WAIT after the 4th pulse (pulses at c1, c4, c7, c10).
        count_in  = CW'(10);
        period_in = PW'(3);
        start_in  = 1'b1;
        tick();
        start_in = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            check($sformatf("abort_run evt c%0d", c), 32'(evt_out),
                  32'((c == 1) || (c == 4) || (c == 7) || (c == 10)));
            if (c < 11) tick();
        end
        check("abort_run busy_in_wait", 32'(busy_out), 32'd1);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check("abort_done", outs3(), 32'b001);
        check("abort_sent", 32'(sent_out), 32'd4);
        tick();
        check("abort_idle", outs3(), 32'b000);
        check("abort_sent_hold", 32'(sent_out), 32'd4);
        burst("after_abort", 2, 2, 1'b0);

        // Start with abort in IDLE is accepted; abort in PULSE keeps and counts that pulse.
        count_in  = CW'(3);
        period_in = PW'(5);
        start_in  = 1'b1;
        abort_in  = 1'b1;
        tick();
        start_in = 1'b0;
        abort_in = 1'b0;
        check("start_abort first", outs3(), 32'b110);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check("pulse_abort done", outs3(), 32'b001);
        check("pulse_abort sent", 32'(sent_out), 32'd1);
        tick();
        check("pulse_abort idle", outs3(), 32'b000);

        burst("n4p2_noise", 4, 2, 1'b1);

        // Reset sampled on the 2nd pulse of N=4, P=2.
        count_in  = CW'(4);
        period_in = PW'(2);
        start_in  = 1'b1;
        tick();
        start_in = 1'b0;
        check("rst_mid c1", outs3(), 32'b110);
        tick();
        check("rst_mid c2", outs3(), 32'b010);
        tick();
        check("rst_mid c3", outs3(), 32'b110);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("rst_mid cleared", 32'({evt_out, busy_out, done_out, sent_out}), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rst_mid quiet c%0d", i), 32'({evt_out, busy_out, done_out, sent_out}), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
